// File: rtl/mux_tdm_pkg.sv
// Shared types and sizing for the time-division 8:1 multiplexer.
package mux_tdm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned N_CH   = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/mux_8_1_gate.sv
// Gate-level combinational 8:1 selector; companion of demux_8_1_gate.
module mux_8_1_gate
    import mux_tdm_pkg::*;
(
    input  logic [N_CH-1:0]  I,
    input  logic [SEL_W-1:0] S,
    output logic             Y
);

    logic [SEL_W-1:0] s_n;
    logic [N_CH-1:0]  term;

    not u_inv0 (s_n[0], S[0]);
    not u_inv1 (s_n[1], S[1]);
    not u_inv2 (s_n[2], S[2]);

    // Each minterm ANDs channel k with the true/complement select literals of k.
    for (genvar k = 0; k < N_CH; k++) begin : g_term
        logic [SEL_W-1:0] lit;
        for (genvar b = 0; b < SEL_W; b++) begin : g_lit
            if (((k >> b) & 1) == 1) begin : g_true
                assign lit[b] = S[b];
            end else begin : g_comp
                assign lit[b] = s_n[b];
            end
        end
        and u_and (term[k], I[k], lit[0], lit[1], lit[2]);
    end

    or u_or (Y, term[0], term[1], term[2], term[3],
                term[4], term[5], term[6], term[7]);

endmodule

// File: rtl/mux_8_1_tdm.sv
// Time-division 8:1 multiplexer: snapshots I on start, then serialises it
// one channel per HOLD-cycle slot onto Y with the matching select on S.
module mux_8_1_tdm
    import mux_tdm_pkg::*;
#(
    parameter int unsigned HOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  I,
    output logic             Y,
    output logic [SEL_W-1:0] S,
    output logic             frame_sync,
    output logic             busy,
    output logic             done
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [SEL_W-1:0]  SLOT_LAST = SEL_W'(N_CH - 1);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   snap_q, snap_d;
    logic [SEL_W-1:0]  slot_q, slot_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              done_d;
    logic              last_hold;
    logic              frame_end;
    logic              y_sel;

    assign last_hold = (hold_q == HOLD_LAST);
    assign frame_end = last_hold && (slot_q == SLOT_LAST);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        slot_d  = slot_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    snap_d  = I;
                    slot_d  = '0;
                    hold_d  = '0;
                end
            end
            SEND: begin
                if (frame_end) begin
                    done_d = 1'b1;
                    slot_d = '0;
                    hold_d = '0;
                    if (start) begin
                        snap_d = I;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (last_hold) begin
                    hold_d = '0;
                    slot_d = slot_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Selector looks at next-cycle snapshot/slot so the registered Y lines up with S.
    mux_8_1_gate u_gate (
        .I (snap_d),
        .S (slot_d),
        .Y (y_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            slot_q     <= '0;
            hold_q     <= '0;
            Y          <= 1'b0;
            S          <= '0;
            frame_sync <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            slot_q     <= slot_d;
            hold_q     <= hold_d;
            done       <= done_d;
            busy       <= (state_d == SEND);
            Y          <= (state_d == SEND) && y_sel;
            S          <= (state_d == SEND) ? slot_d : '0;
            frame_sync <= (state_d == SEND) && (slot_d == '0);
        end
    end

endmodule

// File: tb/tb_mux_8_1_tdm.sv
// Scoreboard bench for mux_8_1_tdm with HOLD=1 and HOLD=3 instances.
module tb_mux_8_1_tdm;

    typedef struct packed {
        logic [2:0] s;
        logic       y;
        logic       fs;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start3;
    logic [7:0] I;
    logic       y1, y3, fs1, fs3, busy1, busy3, done1, done3;
    logic [2:0] s1, s3;

    exp_t        sb[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    mux_8_1_tdm #(.HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .I(I),
        .Y(y1), .S(s1), .frame_sync(fs1), .busy(busy1), .done(done1)
    );

    mux_8_1_tdm #(.HOLD(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .I(I),
        .Y(y3), .S(s3), .frame_sync(fs3), .busy(busy3), .done(done3)
    );

    function automatic exp_t obs(input int d);
        if (d == 3) return {s3, y3, fs3, busy3, done3};
        return {s1, y1, fs1, busy1, done1};
    endfunction

    task automatic push(input logic [2:0] s, input logic y, input logic fs,
                        input logic b, input logic dn);
        sb.push_back({s, y, fs, b, dn});
    endtask

    task automatic push_frame(input logic [7:0] snap, input int hold,
                              input int nslots, input logic first_done);
        for (int k = 0; k < nslots; k++)
            for (int j = 0; j < hold; j++)
                push(3'(k), snap[k], k == 0, 1'b1, first_done && k == 0 && j == 0);
    endtask

    task automatic check_now(input int d, input string tag);
        exp_t e, o;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            o = obs(d);
            assert (o === e) else begin
                n_miss++;
                $error("FAIL %s: observed S=%0d Y=%b fs=%b busy=%b done=%b, expected S=%0d Y=%b fs=%b busy=%b done=%b",
                       tag, o.s, o.y, o.fs, o.busy, o.done, e.s, e.y, e.fs, e.busy, e.done);
            end
        end
    endtask

    task automatic step_check(input int d, input string tag);
        @(negedge clk);
        check_now(d, tag);
    endtask

    initial begin
        logic [7:0] snap;
        logic [7:0] demux;

        // Reset asserted with start high: both instances stay cleared.
        rst_n = 1'b0; start1 = 1'b1; start3 = 1'b1; I = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step_check(1, "reset_h1");
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_now(3, "reset_h3");
        end

        rst_n = 1'b1; start1 = 1'b0; start3 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step_check(1, "idle");
        end

        // Basic HOLD=1 frame.
        I = 8'b1011_0010; start1 = 1'b1;
        push_frame(8'b1011_0010, 1, 8, 1'b0);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step_check(1, "basic");
            start1 = 1'b0;
            I = 8'h00;
        end

        // HOLD=3 with I toggling every cycle; only the snapshot matters.
        I = 8'hA5; start3 = 1'b1;
        push_frame(8'hA5, 3, 8, 1'b0);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 26; c++) begin
            step_check(3, "hold3");
            start3 = 1'b0;
            I = ~I;
        end

        // Back-to-back frames: FF then 00, start held across the frame boundary.
        @(negedge clk);
        I = 8'hFF; start1 = 1'b1;
        push_frame(8'hFF, 1, 8, 1'b0);
        push_frame(8'h00, 1, 8, 1'b1);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            step_check(1, "b2b");
            if (c == 1) I = 8'h00;
            if (c == 9) I = 8'hFF;
            if (c == 9) start1 = 1'b0;
        end

        // Mid-frame reset during slot 4, then a clean full frame.
        @(negedge clk);
        I = 8'h5C; start1 = 1'b1;
        push_frame(8'h5C, 1, 5, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step_check(1, "pre_rst");
            start1 = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now(1, "rst_async");
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step_check(1, "rst_hold");
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            step_check(1, "post_rst");
        end
        I = 8'h3A; start1 = 1'b1;
        push_frame(8'h3A, 1, 8, 1'b0);
        push(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 9; c++) begin
            step_check(1, "restart");
            start1 = 1'b0;
        end

        // Loopback through a demux model over 20 random frames.
        for (int f = 0; f < 20; f++) begin
            snap = 8'($urandom);
            I = snap; start1 = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                start1 = 1'b0;
                I = 8'($urandom);
                demux = 8'(y1) << s1;
                n_vec++;
                assert ({s1, demux} === {3'(k), snap & (8'd1 << k)}) else begin
                    n_miss++;
                    $error("FAIL loopback f%0d k%0d: observed S=%0d demux=%b, expected S=%0d demux=%b",
                           f, k, s1, demux, k, snap & (8'd1 << k));
                end
            end
            push(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            step_check(1, "loop_done");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
